// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared types and constants for the ID->WB control pipeline.
//            Defines the decoded control bundle, forwarding-select codes,
//            ALUop encodings, and a helper that cleans a decoder bundle
//            before it enters ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Control bundle produced by the ID-stage decoder (9 bits, MSB first).
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    // Forwarding mux selects for the EX-stage ALU operands.
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // ALUop encodings driven by the decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // A bubble: no register write, no memory access, no branch.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // The decoder leaves RegDst/MemtoReg undriven (X) for stores and
    // branches. Any bit that is not a clean 1 is taken as 0, and the two
    // write-back-only fields are dropped when nothing is written back, so
    // no unknown ever reaches the EX/MEM/WB muxes.
    function automatic ctrl_t sanitize_ctrl(input ctrl_t raw);
        logic [$bits(ctrl_t)-1:0] bits_in;
        logic [$bits(ctrl_t)-1:0] bits_out;
        ctrl_t                    clean;
        bits_in  = raw;
        bits_out = '0;
        for (int i = 0; i < $bits(ctrl_t); i++) begin
            bits_out[i] = (bits_in[i] === 1'b1);
        end
        clean = bits_out;
        if (!clean.reg_write) begin
            clean.reg_dst    = 1'b0;
            clean.mem_to_reg = 1'b0;
        end
        return clean;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_hazard_pipe_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Purpose  : Combinational EX-stage forwarding selects. A younger producer
//            in EX/MEM wins over an older one in MEM/WB; register 0 is never
//            forwarded.
// Ports    : mem_reg_write/mem_dest - EX/MEM producer
//            wb_reg_write/wb_dest   - MEM/WB producer
//            ex_rs/ex_rt            - EX-stage source registers
//            forward_a/forward_b    - operand A/B mux selects
// Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    function automatic logic [1:0] select_src(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_reg_write && (mem_dest != '0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_dest != '0) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign forward_a = select_src(ex_rs);
    assign forward_b = select_src(ex_rt);

endmodule
`default_nettype wire

// File: rtl/ctrl_hazard_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_hazard_pipe
// Purpose  : Carries decoded control and register addresses through the
//            ID/EX, EX/MEM and MEM/WB registers; detects load-use hazards
//            (one bubble + PC/IF-ID hold), flushes younger instructions on a
//            taken branch resolved in MEM, generates forwarding selects and
//            counts stall cycles (saturating).
// Ports    : id_*          - decoder controls and IF/ID register fields
//            branch_taken  - taken branch in MEM (flush request)
//            ex_*/mem_*/wb_* - pipeline-register outputs per stage
//            forward_a/b   - ALU operand selects
//            pc_write, ifid_write, ifid_flush - front-end control
//            stall_count   - saturating load-use stall counter
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_hazard_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_reg_dst,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  mem_branch,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_count
);

    // ID/EX
    ctrl_t                 r_ex_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    // EX/MEM
    logic                  r_mem_branch;
    logic                  r_mem_mem_read;
    logic                  r_mem_mem_write;
    logic                  r_mem_reg_write;
    logic                  r_mem_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_mem_dest;
    // MEM/WB
    logic                  r_wb_reg_write;
    logic                  r_wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_wb_dest;

    logic [CNT_W-1:0]      r_stall_count;

    ctrl_t                 w_id_ctrl;
    logic [REG_ADDR_W-1:0] w_ex_dest;
    logic                  w_hazard;
    logic                  w_stall;

    assign w_id_ctrl = sanitize_ctrl('{
        reg_dst:    id_reg_dst,
        branch:     id_branch,
        mem_read:   id_mem_read,
        mem_to_reg: id_mem_to_reg,
        alu_op:     id_alu_op,
        mem_write:  id_mem_write,
        alu_src:    id_alu_src,
        reg_write:  id_reg_write
    });

    assign w_ex_dest = r_ex_ctrl.reg_dst ? r_ex_rd : r_ex_rt;

    // Load in EX whose target is read by the instruction in ID. Register 0
    // is hard-wired so a load to it never stalls anybody.
    assign w_hazard = r_ex_ctrl.mem_read && (r_ex_rt != '0) &&
                      ((r_ex_rt == id_rs) || (r_ex_rt == id_rt));

    // A taken branch kills the dependent instruction anyway, so it overrides.
    assign w_stall = w_hazard && !branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl        <= CTRL_BUBBLE;
            r_ex_rs          <= '0;
            r_ex_rt          <= '0;
            r_ex_rd          <= '0;
            r_mem_branch     <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_dest       <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dest        <= '0;
            r_stall_count    <= '0;
        end else begin
            // The branch itself sits in MEM, so MEM/WB always advances.
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_to_reg <= r_mem_mem_to_reg;
            r_wb_dest       <= r_mem_dest;

            if (branch_taken) begin
                r_mem_branch     <= 1'b0;
                r_mem_mem_read   <= 1'b0;
                r_mem_mem_write  <= 1'b0;
                r_mem_reg_write  <= 1'b0;
                r_mem_mem_to_reg <= 1'b0;
                r_mem_dest       <= '0;
            end else begin
                r_mem_branch     <= r_ex_ctrl.branch;
                r_mem_mem_read   <= r_ex_ctrl.mem_read;
                r_mem_mem_write  <= r_ex_ctrl.mem_write;
                r_mem_reg_write  <= r_ex_ctrl.reg_write;
                r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
                r_mem_dest       <= w_ex_dest;
            end

            if (branch_taken || w_stall) begin
                r_ex_ctrl <= CTRL_BUBBLE;
                r_ex_rs   <= '0;
                r_ex_rt   <= '0;
                r_ex_rd   <= '0;
            end else begin
                r_ex_ctrl <= w_id_ctrl;
                r_ex_rs   <= id_rs;
                r_ex_rt   <= id_rt;
                r_ex_rd   <= id_rd;
            end

            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_unit (
        .mem_reg_write (r_mem_reg_write),
        .mem_dest      (r_mem_dest),
        .wb_reg_write  (r_wb_reg_write),
        .wb_dest       (r_wb_dest),
        .ex_rs         (r_ex_rs),
        .ex_rt         (r_ex_rt),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

    assign ex_alu_op     = r_ex_ctrl.alu_op;
    assign ex_alu_src    = r_ex_ctrl.alu_src;
    assign ex_rs         = r_ex_rs;
    assign ex_rt         = r_ex_rt;
    assign ex_dest       = w_ex_dest;
    assign mem_branch    = r_mem_branch;
    assign mem_mem_read  = r_mem_mem_read;
    assign mem_mem_write = r_mem_mem_write;
    assign mem_reg_write = r_mem_reg_write;
    assign mem_dest      = r_mem_dest;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_dest       = r_wb_dest;
    assign pc_write      = !w_stall;
    assign ifid_write    = !w_stall;
    assign ifid_flush    = branch_taken;
    assign stall_count   = r_stall_count;

endmodule
`default_nettype wire
